// File: rtl/fft_stage_sequencer.sv
// Start/stop sequencer for the 2-stage radix-2^2 FFT: coefficient addresses, BF-II control, valid, frame markers; FFTSEQ_FRAME_CNT_EN adds o_frame_cnt.
// Outputs decode registers only (first valid FILL_DLY+1 cycles after start); no backpressure, i_stop honoured at the stage-1 frame boundary.
module fft_stage_sequencer #(
  parameter int FRAME_LEN = 32,
  parameter int ADDR_W    = 5,
  parameter int FILL_DLY  = 16,
  parameter int CTRL_HALF = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_coeff0_en,
  output logic [ADDR_W-1:0] o_coeff0_addr,
  output logic              o_coeff1_en,
  output logic [ADDR_W-1:0] o_coeff1_addr,
  output logic              o_ctrl_bfii,
  output logic              o_enable,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(FILL_DLY - 1);
  localparam logic [ADDR_W-1:0] CTRL_LAST = ADDR_W'(CTRL_HALF - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr0, addr0_nxt;
  logic [ADDR_W-1:0] addr1, addr1_nxt;
  logic [ADDR_W-1:0] fill_cnt, fill_cnt_nxt;
  logic [ADDR_W-1:0] ctrl_cnt, ctrl_cnt_nxt;
  logic              ctrl_bfii, ctrl_bfii_nxt;
  logic              stop_pending, stop_pending_nxt;
  logic              stage1_on, stage2_on;

  assign stage1_on = (state == FILL) || (state == RUN);
  assign stage2_on = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr0        <= '0;
      addr1        <= '0;
      fill_cnt     <= '0;
      ctrl_cnt     <= '0;
      ctrl_bfii    <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr0        <= addr0_nxt;
      addr1        <= addr1_nxt;
      fill_cnt     <= fill_cnt_nxt;
      ctrl_cnt     <= ctrl_cnt_nxt;
      ctrl_bfii    <= ctrl_bfii_nxt;
      stop_pending <= stop_pending_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    addr0_nxt        = addr0;
    addr1_nxt        = addr1;
    fill_cnt_nxt     = fill_cnt;
    ctrl_cnt_nxt     = ctrl_cnt;
    ctrl_bfii_nxt    = ctrl_bfii;
    stop_pending_nxt = stop_pending;

    // Commutator half-period timer runs whenever stage 2 is producing output.
    if (stage2_on) begin
      if (ctrl_cnt == CTRL_LAST) begin
        ctrl_cnt_nxt  = '0;
        ctrl_bfii_nxt = ~ctrl_bfii;
      end else begin
        ctrl_cnt_nxt = ctrl_cnt + 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        if (i_start) begin
          state_nxt        = FILL;
          addr0_nxt        = '0;
          fill_cnt_nxt     = '0;
          stop_pending_nxt = i_stop;
        end
      end
      FILL: begin
        addr0_nxt    = addr0 + 1'b1;
        fill_cnt_nxt = fill_cnt + 1'b1;
        if (i_stop) stop_pending_nxt = 1'b1;
        if (fill_cnt == FILL_LAST) begin
          fill_cnt_nxt  = '0;
          addr1_nxt     = '0;
          ctrl_cnt_nxt  = '0;
          ctrl_bfii_nxt = 1'b0;
          // With FILL_DLY == FRAME_LEN stage 1 can finish its frame on the last fill cycle.
          state_nxt = (stop_pending && addr0 == ADDR_LAST) ? DRAIN : RUN;
        end
      end
      RUN: begin
        addr0_nxt = addr0 + 1'b1;
        addr1_nxt = addr1 + 1'b1;
        if (i_stop) stop_pending_nxt = 1'b1;
        if (stop_pending && addr0 == ADDR_LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        addr1_nxt = addr1 + 1'b1;
        if (addr1 == ADDR_LAST) begin
          state_nxt        = IDLE;
          stop_pending_nxt = 1'b0;
          ctrl_cnt_nxt     = '0;
          ctrl_bfii_nxt    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy        = (state != IDLE);
  assign o_coeff0_en   = stage1_on;
  assign o_coeff0_addr = stage1_on ? addr0 : '0;
  assign o_coeff1_en   = stage2_on;
  assign o_coeff1_addr = stage2_on ? addr1 : '0;
  assign o_ctrl_bfii   = stage2_on & ctrl_bfii;
  assign o_enable      = stage2_on;
  assign o_sof         = stage2_on && (addr1 == '0);
  assign o_eof         = stage2_on && (addr1 == ADDR_LAST);

`ifdef FFTSEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       frame_cnt <= '0;
    else if (o_eof) frame_cnt <= frame_cnt + 16'd1;
  end

  assign o_frame_cnt = frame_cnt;
`else
  assign o_frame_cnt = '0;
`endif

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Central sequencer for the two-stage, 4-sample-per-clock radix-2² FFT pipeline. Replaces the free-running reset-derived enables (coefficient generator enables, 16-cycle stage-2 enable delay, BF-II commutator control counter) with one explicit start/stop state machine. Drives per-stage coefficient address counters, the BF-II block control toggle, the output-valid enable and frame markers.

## Interface
Parameters:
- FRAME_LEN, 32, clock cycles per FFT frame (N/4); power of two, ≥4
- ADDR_W, 5, coefficient address width; log2(FRAME_LEN)
- FILL_DLY, 16, cycles from stage-1 start to stage-2 valid; 1..FRAME_LEN
- CTRL_HALF, 16, BF-II control half-period in cycles; divides FRAME_LEN

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  single-cycle pulse: begin continuous frame processing
- i_stop  in  1  single-cycle pulse: stop after the current frame completes
- o_coeff0_en  out  1  stage-1 coefficient generators run
- o_coeff0_addr  out  ADDR_W  stage-1 twiddle index
- o_coeff1_en  out  1  stage-2 coefficient generators run
- o_coeff1_addr  out  ADDR_W  stage-2 twiddle index
- o_ctrl_bfii  out  1  BF-II commutator select
- o_enable  out  1  pipeline output valid
- o_sof  out  1  first output cycle of a frame
- o_eof  out  1  last output cycle of a frame
- o_busy  out  1  state ≠ IDLE
- o_frame_cnt  out  16  completed output frames (see Configuration)

## Operation
- States: IDLE, FILL, RUN, DRAIN; all registers and outputs reset to 0, state IDLE.
- IDLE: all outputs 0. i_start → FILL; addr0 counter cleared.
- FILL: o_coeff0_en=1, addr0 increments each cycle mod FRAME_LEN; fill counter counts 0..FILL_DLY-1; on terminal count → RUN.
- RUN: o_coeff0_en=1, o_coeff1_en=1, o_enable=1. addr1 starts at 0 on RUN entry and increments mod FRAME_LEN; addr1 lags addr0 by exactly FILL_DLY mod FRAME_LEN. o_sof when addr1=0, o_eof when addr1=FRAME_LEN-1.
- o_ctrl_bfii: 0 on RUN entry, toggles after each CTRL_HALF cycles of RUN/DRAIN; held 0 elsewhere.
- Stop: i_stop in FILL/RUN sets stop_pending. In RUN, when stage-1 completes its frame (addr0=FRAME_LEN-1) with stop_pending set → DRAIN; o_coeff0_en drops next cycle.
- DRAIN: stage-2 signals continue as in RUN; at o_eof → IDLE, stop_pending cleared.
- If stop_pending in FILL, the FILL → RUN → DRAIN progression still completes exactly one frame.
- i_start outside IDLE ignored. i_stop in IDLE or DRAIN ignored. i_start and i_stop together in IDLE: start taken and stop_pending set (one frame).
- Reset assertion mid-operation: immediate return to IDLE, all outputs 0, no partial-frame completion.

## Timing
- i_start sampled at edge 0: o_busy, o_coeff0_en =1, o_coeff0_addr=0 from cycle 1.
- o_enable, o_sof, o_coeff1_en first high at cycle 1+FILL_DLY; addr1=0 there.
- All outputs registered; no combinational path from inputs to outputs.
- Continuous RUN: o_sof every FRAME_LEN cycles, o_eof FRAME_LEN-1 cycles after each o_sof, no gaps.
- After stop: last o_eof followed by o_enable=0 and o_busy=0 on the next cycle.

## Configuration
- FFTSEQ_FRAME_CNT_EN defined: o_frame_cnt increments (wrapping at 2^16) on every cycle with o_eof=1; cleared only by reset.
- Not defined: counter omitted, o_frame_cnt tied to 0.

## Test plan
- Reset, then i_start at cycle 0 (defaults) -> o_coeff0_en=1 at cycle 1; o_enable, o_sof at cycle 17 with o_coeff1_addr=0; o_eof at 48.
- Continuous run 4 frames -> o_sof at cycles 17,49,81,113; o_ctrl_bfii toggles at 33,49,65…; o_coeff0_addr−o_coeff1_addr ≡16 mod 32 during RUN.
- i_stop at cycle 40 -> o_coeff0_en falls at 65, last o_eof at 80, o_busy=0 at 81; with macro, o_frame_cnt=2.
- i_start and i_stop same cycle in IDLE -> exactly one frame: single o_sof at 17, o_eof at 48, idle at 49.
- rst low at cycle 30 mid-RUN -> all outputs 0 asynchronously; i_start ignored while rst low; restart after release gives cycle-17 sof again.
- i_start pulsed during RUN -> no effect on counters or markers.
